// File: rtl/stopwatch_counter.sv
// Stopwatch timebase: input conditioning, pause debounce, prescaler and BCD MM:SS counting.
// Optional STOPWATCH_PRESET_EN adds a load/load_val digit preset port pair.
module stopwatch_counter #(
  parameter int CLK_HZ     = 100000000,
  parameter int DEB_CYCLES = 1000000,
  parameter int UPD_DIV    = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adj,
  input  logic        sel,
  input  logic        pse,
`ifdef STOPWATCH_PRESET_EN
  input  logic        load,
  input  logic [15:0] load_val,
`endif
  output logic [3:0]  sec_one,
  output logic [3:0]  sec_ten,
  output logic [3:0]  min_one,
  output logic [3:0]  min_ten,
  output logic        blink,
  output logic        update_tick,
  output logic        paused
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int UW = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;

  logic          adj_m, adj_s, sel_m, sel_s, pse_m, pse_s;
  logic [DW-1:0] deb_cnt;
  logic          deb_level, deb_q;
  logic [PW-1:0] presc;
  logic [UW-1:0] upd_cnt;
  logic          adj_chg, tick_1hz, tick_2hz, run_tick, blink_tick, do_load;
  logic [3:0]    sec_one_n, sec_ten_n, min_one_n, min_ten_n;
  logic [3:0]    sec_one_inc, sec_ten_inc, min_one_inc, min_ten_inc;
  logic          sec_wrap;

`ifdef STOPWATCH_PRESET_EN
  assign do_load = load;
`else
  assign do_load = 1'b0;
`endif

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  // NOTE: every flop uses non-blocking assignment so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {adj_m, adj_s, sel_m, sel_s, pse_m, pse_s} <= '0;
    end else begin
      {adj_m, sel_m, pse_m} <= {adj, sel, pse};
      {adj_s, sel_s, pse_s} <= {adj_m, sel_m, pse_m};
    end
  end

  // Debounce counts consecutive samples disagreeing with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
      deb_q     <= 1'b0;
      paused    <= 1'b0;
    end else begin
      deb_q <= deb_level;
      if (pse_s != deb_level) begin
        if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
          deb_level <= pse_s;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
      if (deb_level && !deb_q) paused <= ~paused;
    end
  end

  // adj_chg flags the edge on which adj_s is about to change.
  assign adj_chg    = adj_m ^ adj_s;
  assign tick_1hz   = (presc == PW'(CLK_HZ - 1)) && !paused;
  assign tick_2hz   = ((presc == PW'(CLK_HZ / 2 - 1)) || (presc == PW'(CLK_HZ - 1))) && !paused;
  assign run_tick   = tick_1hz && !adj_s && !adj_chg;
  assign blink_tick = tick_2hz && adj_s && !adj_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 presc <= '0;
    else if (adj_chg || do_load) presc <= '0;
    else if (!paused)           presc <= (presc == PW'(CLK_HZ - 1)) ? '0 : presc + 1'b1;
  end

  assign sec_wrap    = (sec_one == 4'd9) && (sec_ten == 4'd5);
  assign sec_one_inc = (sec_one == 4'd9) ? 4'd0 : sec_one + 4'd1;
  assign sec_ten_inc = (sec_one != 4'd9) ? sec_ten : (sec_ten == 4'd5) ? 4'd0 : sec_ten + 4'd1;
  assign min_one_inc = (min_one == 4'd9) ? 4'd0 : min_one + 4'd1;
  assign min_ten_inc = (min_one != 4'd9) ? min_ten : (min_ten == 4'd9) ? 4'd0 : min_ten + 4'd1;

  // NOTE: defaults first so no path through this block can infer a latch.
  always_comb begin
    {min_ten_n, min_one_n, sec_ten_n, sec_one_n} = {min_ten, min_one, sec_ten, sec_one};
    if (do_load) begin
`ifdef STOPWATCH_PRESET_EN
      sec_one_n = clamp(load_val[3:0],   4'd9);
      sec_ten_n = clamp(load_val[7:4],   4'd5);
      min_one_n = clamp(load_val[11:8],  4'd9);
      min_ten_n = clamp(load_val[15:12], 4'd9);
`endif
    end else if (run_tick) begin
      {sec_ten_n, sec_one_n} = {sec_ten_inc, sec_one_inc};
      if (sec_wrap) {min_ten_n, min_one_n} = {min_ten_inc, min_one_inc};
    end else if (blink_tick) begin
      if (sel_s) {sec_ten_n, sec_one_n} = {sec_ten_inc, sec_one_inc};
      else       {min_ten_n, min_one_n} = {min_ten_inc, min_one_inc};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {min_ten, min_one, sec_ten, sec_one} <= '0;
      blink <= 1'b0;
    end else begin
      {min_ten, min_one, sec_ten, sec_one} <= {min_ten_n, min_one_n, sec_ten_n, sec_one_n};
      // Clearing on adj_m keeps blink low for every cycle adj_s is low.
      if (!adj_m)          blink <= 1'b0;
      else if (blink_tick) blink <= ~blink;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) upd_cnt <= '0;
    else        upd_cnt <= (upd_cnt == UW'(UPD_DIV - 1)) ? '0 : upd_cnt + 1'b1;
  end

  assign update_tick = (upd_cnt == UW'(UPD_DIV - 1));

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Timebase and BCD time-keeping core of the stopwatch; produces the MM:SS digits, blink level and scan-update tick that the 7-segment display block consumes.
- Takes raw adj/sel levels and a raw pause button; all enables are single-cycle pulses in the one master clock domain. No derived clocks.
- Supports run, pause and adjust modes. Adjust mode has a minutes/seconds select.

Parameters:
- CLK_HZ, 100000000, master clock cycles per second; must be even and >= 4.
- DEB_CYCLES, 1000000, consecutive stable cycles required to accept a new debounced pause-button level.
- UPD_DIV, 100000, master cycles per update_tick pulse (display scan rate).

Ports:
- clk  in  1  master clock.
- rst_n  in  1  asynchronous active-low reset.
- adj  in  1  raw adjust switch; 1 = adjust mode.
- sel  in  1  raw select switch; 0 = adjust minutes, 1 = adjust seconds.
- pse  in  1  raw pause pushbutton, active high.
- sec_one  out  4  seconds units, BCD 0-9.
- sec_ten  out  4  seconds tens, BCD 0-5.
- min_one  out  4  minutes units, BCD 0-9.
- min_ten  out  4  minutes tens, BCD 0-9.
- blink  out  1  blink level for the display; 0 whenever not in adjust mode.
- update_tick  out  1  one-cycle pulse every UPD_DIV cycles.
- paused  out  1  current pause state.

Behaviour:
- Reset, async on rst_n=0:
  - All digits 0; blink=0; update_tick=0; paused=0.
  - Prescaler, update divider, debounce counter and synchroniser flops all 0.
- Input conditioning:
  - adj, sel and pse each pass through a 2-flop synchroniser. Synchronised levels adj_s and sel_s take effect 2 cycles after the input changes.
  - pse_s is debounced: a new level is accepted after DEB_CYCLES consecutive equal samples that differ from the current debounced level.
  - A 0->1 transition of the debounced level toggles paused on the next edge. Release does nothing.
- Prescaler:
  - Counts 0..CLK_HZ-1 and wraps to 0.
  - Advances only when paused=0. Holds its value while paused, so a fractional second is preserved.
  - Cleared to 0 on any change of adj_s; the clear takes priority over advance.
  - tick_1hz = (prescaler == CLK_HZ-1) and not paused.
  - tick_2hz = (prescaler == CLK_HZ/2-1 or prescaler == CLK_HZ-1) and not paused.
- Run mode (adj_s=0): on tick_1hz the digits increment as BCD MM:SS, all digit registers updating on the same edge.
  - sec_one 9 -> 0 carries into sec_ten.
  - sec_ten 5 -> 0 carries into min_one.
  - min_one 9 -> 0 carries into min_ten.
  - 99:59 -> 00:00.
  - First increment lands on edge CLK_HZ after rst_n release, counting edges from 1.
- Adjust mode (adj_s=1): no 1 Hz counting; on each tick_2hz:
  - sel_s=0: minutes increment 00..99, 99 -> 00; seconds unchanged.
  - sel_s=1: seconds increment 00..59, 59 -> 00; no carry into minutes.
  - blink toggles on each tick_2hz, giving a 1 Hz square wave.
  - blink forced to 0 on the edge after adj_s falls.
- Pause applies in both modes: digits and blink freeze.
- update_tick: a free-running divider that is never paused. It pulses when the count reaches UPD_DIV-1, then wraps.
- Simultaneous events:
  - An adj_s change and a tick on the same cycle: the tick is suppressed and the prescaler clears.
  - A pause toggle and a tick on the same cycle: the tick applies and paused takes effect afterwards.
- Invariants: digit outputs never leave their legal BCD ranges.

Optional Feature:
- Macro STOPWATCH_PRESET_EN.
- When defined: adds input load (1 bit) and input load_val (16 bits, {min_ten,min_one,sec_ten,sec_one}).
  - load=1 writes load_val into the digits on that edge. load has priority over any tick.
  - Each nibble is clamped to its legal maximum: 9, 5, 9, 9 in load_val order from sec_one upward.
  - The load clears the prescaler.
- When undefined: the load and load_val ports do not exist and the digits change only by counting.

Test Plan (CLK_HZ=8, DEB_CYCLES=3, UPD_DIV=4):
- Reset release, adj=0, pse=0, run 8 cycles -> digits 00:01 at edge 8; after 480 cycles -> 01:00.
- Run from 99:59 (preset, or 5999 s of ticks) -> next tick gives 00:00 with no stray value.
- pse high for 2 cycles -> no toggle. pse high for 6 cycles -> paused=1 and digits frozen; repeat the press -> paused=0 and counting resumes with the fractional-second phase intact.
- adj=1, sel=0 from 00:30, 20 cycles -> minutes advance every 4 cycles, seconds stay 30, blink toggles every 4 cycles; sel=1 from 00:58 -> 00:59, 00:00, minutes unchanged.
- adj 1 -> 0 -> blink=0 by 3 cycles after the change; first 1 Hz tick exactly 8 cycles after adj_s changes.
- rst_n pulsed low mid-count at 12:34 -> all outputs 0 immediately, without waiting for a clock edge; update_tick period is 4 cycles throughout, including while paused.
